// File: rtl/game_pkg.sv
// Shared state encodings, playfield geometry and reset/spawn constants for the
// game engine and the renderer that consumes its outputs.
package game_pkg;

   typedef enum logic [1:0] {
      S_START        = 2'b00,
      S_PLAYING      = 2'b01,
      S_INSTRUCTIONS = 2'b10,
      S_GAME_OVER    = 2'b11
   } game_state_t;

   localparam logic [9:0] BOX_WIDTH       = 10'd30;
   localparam logic [9:0] BOX_BASE_HEIGHT = 10'd30;
   localparam logic [9:0] BOX_Y_START     = 10'd315;
   localparam logic [9:0] BANK_X_START    = 10'd50;
   localparam logic [9:0] BANK_WIDTH      = 10'd60;
   localparam logic [9:0] OBJ_SIZE        = 10'd20;
   localparam logic [9:0] PLAYER_STEP     = 10'd4;
   localparam logic [9:0] OBST_SPEED      = 10'd3;
   localparam logic [2:0] START_HP        = 3'd3;

   localparam logic [9:0] SCREEN_WIDTH  = 10'd640;
   localparam logic [9:0] PLAYER_X_MAX  = SCREEN_WIDTH - BOX_WIDTH;
   localparam logic [9:0] CARRY_HEIGHT  = BOX_BASE_HEIGHT + OBJ_SIZE;
   localparam logic [9:0] GREEN_Y_START = BOX_Y_START - OBJ_SIZE + 10'd1;
   localparam logic [9:0] LFSR_SEED     = 10'h2A5;

   localparam logic [10:0] SPAWN_X_BASE  = 11'd120;
   localparam logic [10:0] SPAWN_X_LIMIT = 11'd600;
   localparam logic [10:0] SPAWN_X_WRAP  = 11'd256;

   typedef struct packed {
      logic [9:0] player_x;
      logic [9:0] player_height;
      logic [9:0] obstacle_x;
      logic [9:0] obstacle_y;
      logic [9:0] green_x;
      logic       green_active;
      logic [7:0] bank_level;
      logic [2:0] hp;
   } game_regs_t;

   localparam game_regs_t GAME_RESET = '{
      player_x:      10'd300,
      player_height: BOX_BASE_HEIGHT,
      obstacle_x:    10'd320,
      obstacle_y:    10'd0,
      green_x:       10'd400,
      green_active:  1'b1,
      bank_level:    8'd0,
      hp:            START_HP
   };

   function automatic logic [10:0] ext11(input logic [9:0] v);
      return {1'b0, v};
   endfunction

   // Half-open spans [lo, hi) overlap test.
   function automatic logic spans_overlap(input logic [10:0] a_lo, input logic [10:0] a_hi,
                                          input logic [10:0] b_lo, input logic [10:0] b_hi);
      return (a_lo < b_hi) && (b_lo < a_hi);
   endfunction

   function automatic logic [9:0] spawn_x(input logic [9:0] lfsr);
      logic [10:0] raw;
      logic [10:0] folded;
      raw    = SPAWN_X_BASE + {2'b00, lfsr[8:0]};
      folded = (raw >= SPAWN_X_LIMIT) ? (raw - SPAWN_X_WRAP) : raw;
      return folded[9:0];
   endfunction

endpackage

// File: rtl/game_if.sv
// Controls in, renderer-facing game state out; master is the game engine.
interface game_if;
   import game_pkg::*;

   logic        frame_tick;
   logic        btn_left;
   logic        btn_right;
   logic        btn_select;
   game_state_t game_state;
   logic        menu_selection;
   logic [9:0]  player_x;
   logic [9:0]  player_height;
   logic [9:0]  obstacle_x;
   logic [9:0]  obstacle_y;
   logic [9:0]  obstacle_width;
   logic [9:0]  obstacle_height;
   logic [9:0]  green_x;
   logic [9:0]  green_y;
   logic [9:0]  green_width;
   logic [9:0]  green_height;
   logic        green_active;
   logic [7:0]  bank_level;
   logic [2:0]  hp;

   modport master (
      input  frame_tick, btn_left, btn_right, btn_select,
      output game_state, menu_selection, player_x, player_height,
             obstacle_x, obstacle_y, obstacle_width, obstacle_height,
             green_x, green_y, green_width, green_height, green_active,
             bank_level, hp
   );

   modport slave (
      output frame_tick, btn_left, btn_right, btn_select,
      input  game_state, menu_selection, player_x, player_height,
             obstacle_x, obstacle_y, obstacle_width, obstacle_height,
             green_x, green_y, green_width, green_height, green_active,
             bank_level, hp
   );

endinterface

// File: rtl/game_lfsr.sv
// Free-running 10-bit Fibonacci LFSR (x^10 + x^7 + 1) used as the spawn-x source.
module game_lfsr
   import game_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   output logic [9:0] lfsr
);

   // Advance every clock; reset reseeds.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lfsr <= LFSR_SEED;
      end else begin
         lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
      end
   end

endmodule

// File: rtl/game_controller.sv
// Frame-rate game engine: menu/state machine, object motion, collisions,
// pickup/deposit scoring and HP, all exposed as registered renderer inputs.
module game_controller
   import game_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   game_if.master bus
);

   game_state_t state_r;
   logic        menu_sel_r;
   logic        left_prev_r;
   logic        right_prev_r;
   logic        select_prev_r;
   game_regs_t  game_r;
   game_regs_t  game_nxt_s;

   logic [9:0]  lfsr_s;
   logic [9:0]  spawn_x_s;
   logic [9:0]  player_x_nxt_s;
   logic        left_edge_s;
   logic        right_edge_s;
   logic        select_edge_s;
   logic [10:0] player_lo_s;
   logic [10:0] player_hi_s;
   logic [10:0] player_top_s;
   logic [10:0] obst_x_s;
   logic [10:0] obst_y_s;
   logic [10:0] green_x_s;
   logic        hit_s;
   logic        floor_s;
   logic        pickup_s;
   logic        deposit_s;

   game_lfsr u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .lfsr  (lfsr_s)
   );

   assign left_edge_s   = bus.btn_left   & ~left_prev_r;
   assign right_edge_s  = bus.btn_right  & ~right_prev_r;
   assign select_edge_s = bus.btn_select & ~select_prev_r;
   assign spawn_x_s     = spawn_x(lfsr_s);

   // Geometry is widened to 11 bits so right/bottom edges never wrap.
   assign player_lo_s  = ext11(game_r.player_x);
   assign player_hi_s  = player_lo_s + ext11(BOX_WIDTH);
   assign player_top_s = ext11(BOX_Y_START) + 11'd1 - ext11(game_r.player_height);
   assign obst_x_s     = ext11(game_r.obstacle_x);
   assign obst_y_s     = ext11(game_r.obstacle_y);
   assign green_x_s    = ext11(game_r.green_x);

   assign hit_s = spans_overlap(obst_x_s, obst_x_s + ext11(OBJ_SIZE), player_lo_s, player_hi_s)
               && spans_overlap(obst_y_s, obst_y_s + ext11(OBJ_SIZE),
                                player_top_s, ext11(BOX_Y_START) + 11'd1);
   assign floor_s   = (obst_y_s + ext11(OBJ_SIZE)) > ext11(BOX_Y_START);
   assign pickup_s  = game_r.green_active
                   && spans_overlap(green_x_s, green_x_s + ext11(OBJ_SIZE), player_lo_s, player_hi_s);
   assign deposit_s = (game_r.player_height > BOX_BASE_HEIGHT)
                   && spans_overlap(ext11(BANK_X_START), ext11(BANK_X_START) + ext11(BANK_WIDTH),
                                    player_lo_s, player_hi_s);

   // Horizontal move from the held button levels, clamped to the screen.
   always_comb begin
      player_x_nxt_s = game_r.player_x;
      if (bus.btn_left && !bus.btn_right) begin
         if (game_r.player_x < PLAYER_STEP) player_x_nxt_s = 10'd0;
         else                               player_x_nxt_s = game_r.player_x - PLAYER_STEP;
      end else if (bus.btn_right && !bus.btn_left) begin
         if (game_r.player_x > PLAYER_X_MAX - PLAYER_STEP) player_x_nxt_s = PLAYER_X_MAX;
         else                                              player_x_nxt_s = game_r.player_x + PLAYER_STEP;
      end else begin
         player_x_nxt_s = game_r.player_x;
      end
   end

   // One frame of physics; a hit pre-empts the floor rule so only one respawn happens.
   always_comb begin
      game_nxt_s          = game_r;
      game_nxt_s.player_x = player_x_nxt_s;
      if (hit_s) begin
         game_nxt_s.obstacle_x = spawn_x_s;
         game_nxt_s.obstacle_y = 10'd0;
         game_nxt_s.hp         = game_r.hp - 3'd1;
      end else if (floor_s) begin
         game_nxt_s.obstacle_x = spawn_x_s;
         game_nxt_s.obstacle_y = 10'd0;
      end else begin
         game_nxt_s.obstacle_y = game_r.obstacle_y + OBST_SPEED;
      end
      if (deposit_s) begin
         if (game_r.bank_level != 8'hFF) game_nxt_s.bank_level = game_r.bank_level + 8'd1;
         else                            game_nxt_s.bank_level = game_r.bank_level;
         game_nxt_s.player_height = BOX_BASE_HEIGHT;
         game_nxt_s.green_x       = spawn_x_s;
         game_nxt_s.green_active  = 1'b1;
      end else if (pickup_s) begin
         game_nxt_s.green_active  = 1'b0;
         game_nxt_s.player_height = CARRY_HEIGHT;
      end else begin
         game_nxt_s.green_active  = game_r.green_active;
      end
   end

   // Menu/state machine, frame-gated game registers and button history.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r       <= S_START;
         menu_sel_r    <= 1'b0;
         left_prev_r   <= 1'b0;
         right_prev_r  <= 1'b0;
         select_prev_r <= 1'b0;
         game_r        <= GAME_RESET;
      end else begin
         left_prev_r   <= bus.btn_left;
         right_prev_r  <= bus.btn_right;
         select_prev_r <= bus.btn_select;
         case (state_r)
            S_START: begin
               if (select_edge_s) begin
                  if (!menu_sel_r) begin
                     state_r <= S_PLAYING;
                     game_r  <= GAME_RESET;
                  end else begin
                     state_r <= S_INSTRUCTIONS;
                  end
               end else if (left_edge_s || right_edge_s) begin
                  menu_sel_r <= ~menu_sel_r;
               end
            end
            S_INSTRUCTIONS: begin
               if (select_edge_s) state_r <= S_START;
            end
            S_PLAYING: begin
               if (bus.frame_tick) begin
                  game_r <= game_nxt_s;
                  if (hit_s && (game_r.hp == 3'd1)) state_r <= S_GAME_OVER;
               end
            end
            S_GAME_OVER: begin
               if (select_edge_s) begin
                  state_r    <= S_START;
                  menu_sel_r <= 1'b0;
               end
            end
            default: state_r <= S_START;
         endcase
      end
   end

   assign bus.game_state      = state_r;
   assign bus.menu_selection  = menu_sel_r;
   assign bus.player_x        = game_r.player_x;
   assign bus.player_height   = game_r.player_height;
   assign bus.obstacle_x      = game_r.obstacle_x;
   assign bus.obstacle_y      = game_r.obstacle_y;
   assign bus.obstacle_width  = OBJ_SIZE;
   assign bus.obstacle_height = OBJ_SIZE;
   assign bus.green_x         = game_r.green_x;
   assign bus.green_y         = GREEN_Y_START;
   assign bus.green_width     = OBJ_SIZE;
   assign bus.green_height    = OBJ_SIZE;
   assign bus.green_active    = game_r.green_active;
   assign bus.bank_level      = game_r.bank_level;
   assign bus.hp              = game_r.hp;

endmodule

// File: tb/tb_game_controller.sv
// Scenario bench for game_controller: a behavioural game model predicts the
// outputs, predictions are queued as stimulus is applied and popped on compare.
module tb_game_controller;
   import game_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   game_if bus ();

   game_controller dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] st;
      logic       sel;
      logic [9:0] px, ph, ox, oy, ow, oh, gx, gy, gw, gh;
      logic       ga;
      logic [7:0] bank;
      logic [2:0] hp;
   } snap_t;

   snap_t      m;
   logic [9:0] m_lfsr;
   bit         m_pl, m_pr, m_ps;
   snap_t      exp_q[$];
   int         n_checks = 0;
   int         n_fail   = 0;

   function automatic snap_t reset_snap();
      snap_t s;
      s.st = 2'd0;    s.sel = 1'b0;
      s.px = 10'd300; s.ph = 10'd30;
      s.ox = 10'd320; s.oy = 10'd0;   s.ow = 10'd20; s.oh = 10'd20;
      s.gx = 10'd400; s.gy = 10'd296; s.gw = 10'd20; s.gh = 10'd20;
      s.ga = 1'b1;    s.bank = 8'd0;  s.hp = 3'd3;
      return s;
   endfunction

   function automatic snap_t dut_snap();
      snap_t s;
      s.st = bus.game_state;     s.sel = bus.menu_selection;
      s.px = bus.player_x;       s.ph = bus.player_height;
      s.ox = bus.obstacle_x;     s.oy = bus.obstacle_y;
      s.ow = bus.obstacle_width; s.oh = bus.obstacle_height;
      s.gx = bus.green_x;        s.gy = bus.green_y;
      s.gw = bus.green_width;    s.gh = bus.green_height;
      s.ga = bus.green_active;   s.bank = bus.bank_level; s.hp = bus.hp;
      return s;
   endfunction

   // Behavioural reference of one clock edge of the game.
   function automatic snap_t model_next(input snap_t c, input bit l, input bit r,
                                        input bit el, input bit er, input bit es,
                                        input bit tick, input logic [9:0] lf);
      snap_t n;
      int px, top, ox, oy, gx, sx;
      bit hit, flr, pick, dep;
      n = c;
      case (c.st)
         2'd0: begin
            if (es) begin
               if (c.sel == 1'b0) begin n = reset_snap(); n.st = 2'd1; end
               else n.st = 2'd2;
            end else if (el || er) n.sel = ~c.sel;
         end
         2'd2: if (es) n.st = 2'd0;
         2'd3: if (es) begin n.st = 2'd0; n.sel = 1'b0; end
         2'd1: if (tick) begin
            px = int'(c.px); ox = int'(c.ox); oy = int'(c.oy); gx = int'(c.gx);
            top = 316 - int'(c.ph);
            sx = 120 + int'(lf[8:0]);
            if (sx >= 600) sx = sx - 256;
            hit  = (ox < px + 30) && (px < ox + 20) && (oy <= 315) && (top <= oy + 19);
            flr  = !hit && (oy + 20 > 315);
            pick = c.ga && (gx < px + 30) && (px < gx + 20);
            dep  = (c.ph > 10'd30) && (px + 30 > 50) && (px < 110);
            if (l && !r)      n.px = (px >= 4) ? 10'(px - 4) : 10'd0;
            else if (r && !l) n.px = (px + 4 <= 610) ? 10'(px + 4) : 10'd610;
            if (hit || flr) begin
               n.ox = 10'(sx); n.oy = 10'd0;
               if (hit) n.hp = c.hp - 3'd1;
            end else n.oy = c.oy + 10'd3;
            if (hit && c.hp == 3'd1) n.st = 2'd3;
            if (dep) begin
               n.bank = (c.bank == 8'd255) ? c.bank : c.bank + 8'd1;
               n.ph = 10'd30; n.gx = 10'(sx); n.ga = 1'b1;
            end else if (pick) begin
               n.ga = 1'b0; n.ph = 10'd50;
            end
         end
         default: n = c;
      endcase
      return n;
   endfunction

   // Drive one clock of inputs; optionally queue the predicted post-edge outputs.
   task automatic step(input bit l, input bit r, input bit s, input bit tick, input bit push);
      snap_t e;
      bus.btn_left = l; bus.btn_right = r; bus.btn_select = s; bus.frame_tick = tick;
      if (!rst_n) e = reset_snap();
      else        e = model_next(m, l, r, l & !m_pl, r & !m_pr, s & !m_ps, tick, m_lfsr);
      if (push) exp_q.push_back(e);
      @(posedge clk);
      if (!rst_n) begin
         m_lfsr = LFSR_SEED; m_pl = 1'b0; m_pr = 1'b0; m_ps = 1'b0;
      end else begin
         m_lfsr = {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
         m_pl = l; m_pr = r; m_ps = s;
      end
      m = e;
      #1;
   endtask

   task automatic frame(input bit l, input bit r);
      step(l, r, 1'b0, 1'b1, 1'b0);
      step(l, r, 1'b0, 1'b0, 1'b0);
      step(l, r, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic start_game();
      snap_t e, a;
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      e = exp_q.pop_front(); a = dut_snap(); n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL start_game: got %h want %h", a, e); end
      n_checks++;
      if (bus.game_state !== S_PLAYING || bus.player_x !== 10'd300 || bus.obstacle_y !== 10'd0) begin
         n_fail++;
         $display("FAIL start_reload: state %0d px %0d oy %0d, want 1 300 0",
                  bus.game_state, bus.player_x, bus.obstacle_y);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      snap_t e, a;
      rst_n = 1'b0;
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      e = exp_q.pop_front(); a = dut_snap(); n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL reset: got %h want %h", a, e); end
      rst_n = 1'b1;
      repeat (3) begin
         frame(1'b0, 1'b0);
         e = exp_q.pop_front(); a = dut_snap(); n_checks++;
         if (a !== e) begin n_fail++; $display("FAIL idle_frames: got %h want %h", a, e); end
      end
      n_checks++;
      if (bus.hp !== 3'd3 || bus.game_state !== S_START) begin
         n_fail++; $display("FAIL idle_hold: hp %0d state %0d, want 3 0", bus.hp, bus.game_state);
      end
   endtask

   task automatic test_menu();
      snap_t e, a;
      bit l_seq [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      bit r_seq [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      bit s_seq [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [1:0] st_want [7] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd0, 2'd0};
      logic       sel_want [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 7; i++) begin
         step(l_seq[i], r_seq[i], s_seq[i], 1'b0, 1'b1);
         e = exp_q.pop_front(); a = dut_snap(); n_checks++;
         if (a !== e) begin n_fail++; $display("FAIL menu[%0d]: got %h want %h", i, a, e); end
         n_checks++;
         if (bus.game_state !== st_want[i] || bus.menu_selection !== sel_want[i]) begin
            n_fail++;
            $display("FAIL menu_state[%0d]: state %0d sel %0d, want %0d %0d",
                     i, bus.game_state, bus.menu_selection, st_want[i], sel_want[i]);
         end
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_move_left_and_floor();
      snap_t e, a;
      start_game();
      for (int f = 1; f <= 100; f++) begin
         frame(1'b1, 1'b0);
         e = exp_q.pop_front(); a = dut_snap(); n_checks++;
         if (a !== e) begin n_fail++; $display("FAIL left_frame%0d: got %h want %h", f, a, e); end
         if (f == 74 || f == 75 || f == 80) begin
            n_checks++;
            if (bus.player_x !== ((f == 74) ? 10'd4 : 10'd0)) begin
               n_fail++; $display("FAIL left_clamp f%0d: px %0d", f, bus.player_x);
            end
         end
         if (f == 99 || f == 100) begin
            n_checks++;
            if (bus.obstacle_y !== ((f == 99) ? 10'd297 : 10'd0) || bus.hp !== 3'd3) begin
               n_fail++; $display("FAIL floor f%0d: oy %0d hp %0d", f, bus.obstacle_y, bus.hp);
            end
         end
      end
      n_checks++;
      if (bus.obstacle_x < 10'd120 || bus.obstacle_x > 10'd599) begin
         n_fail++; $display("FAIL floor_spawn: ox %0d, want 120..599", bus.obstacle_x);
      end
   endtask

   task automatic test_reset_midgame();
      snap_t e, a;
      rst_n = 1'b0;
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      e = exp_q.pop_front(); a = dut_snap(); n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL midgame_reset: got %h want %h", a, e); end
      n_checks++;
      if (bus.game_state !== S_START || bus.player_x !== 10'd300 || bus.obstacle_x !== 10'd320) begin
         n_fail++;
         $display("FAIL midgame_values: state %0d px %0d ox %0d", bus.game_state, bus.player_x, bus.obstacle_x);
      end
      rst_n = 1'b1;
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_pickup_deposit();
      snap_t e, a;
      int f;
      start_game();
      for (int k = 1; k <= 85; k++) begin
         frame(1'b0, 1'b1);
         e = exp_q.pop_front(); a = dut_snap(); n_checks++;
         if (a !== e) begin n_fail++; $display("FAIL right_frame%0d: got %h want %h", k, a, e); end
         if (k == 18 || k == 19) begin
            n_checks++;
            if (bus.green_active !== (k == 18) || bus.player_height !== ((k == 18) ? 10'd30 : 10'd50)) begin
               n_fail++; $display("FAIL pickup f%0d: ga %0d h %0d", k, bus.green_active, bus.player_height);
            end
         end
         if (k == 77 || k == 78 || k == 85) begin
            n_checks++;
            if (bus.player_x !== ((k == 77) ? 10'd608 : 10'd610)) begin
               n_fail++; $display("FAIL right_clamp f%0d: px %0d", k, bus.player_x);
            end
         end
      end
      f = 0;
      while (f < 200 && m.bank == 8'd0) begin
         frame(1'b1, 1'b0);
         e = exp_q.pop_front(); a = dut_snap(); n_checks++;
         if (a !== e) begin n_fail++; $display("FAIL deposit_walk%0d: got %h want %h", f, a, e); end
         f++;
      end
      n_checks++;
      if (bus.bank_level !== 8'd1 || bus.player_height !== 10'd30 || bus.green_active !== 1'b1
          || bus.green_x < 10'd120 || bus.green_x > 10'd599) begin
         n_fail++;
         $display("FAIL deposit: bank %0d h %0d ga %0d gx %0d after %0d frames",
                  bus.bank_level, bus.player_height, bus.green_active, bus.green_x, f);
      end
   endtask

   task automatic test_hits();
      snap_t e, a;
      logic [2:0] hp_prev;
      int d, hits;
      bit l, r;
      rst_n = 1'b0;
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      e = exp_q.pop_front(); a = dut_snap(); n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL hits_reset: got %h want %h", a, e); end
      rst_n = 1'b1;
      start_game();
      hp_prev = 3'd3;
      hits = 0;
      for (int f = 0; f < 3000 && m.st != 2'd3; f++) begin
         d = int'(m.ox) - 5 - int'(m.px);
         l = (d <= -4);
         r = (d >= 4);
         frame(l, r);
         e = exp_q.pop_front(); a = dut_snap(); n_checks++;
         if (a !== e) begin n_fail++; $display("FAIL hits_frame%0d: got %h want %h", f, a, e); end
         if (bus.hp !== hp_prev) begin
            hits++;
            n_checks++;
            if (bus.hp !== hp_prev - 3'd1) begin
               n_fail++; $display("FAIL hp_step: hp %0d after %0d", bus.hp, hp_prev);
            end
            n_checks++;
            if ((bus.hp == 3'd0) !== (bus.game_state == S_GAME_OVER)) begin
               n_fail++; $display("FAIL game_over_edge: hp %0d state %0d", bus.hp, bus.game_state);
            end
            hp_prev = bus.hp;
         end
      end
      n_checks++;
      if (hits != 3 || bus.hp !== 3'd0 || bus.game_state !== S_GAME_OVER) begin
         n_fail++;
         $display("FAIL three_hits: hits %0d hp %0d state %0d, want 3 0 3", hits, bus.hp, bus.game_state);
      end
   endtask

   task automatic test_game_over_exit();
      snap_t e, a;
      frame(1'b1, 1'b0);
      e = exp_q.pop_front(); a = dut_snap(); n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL over_hold: got %h want %h", a, e); end
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      e = exp_q.pop_front(); a = dut_snap(); n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL over_exit: got %h want %h", a, e); end
      n_checks++;
      if (bus.game_state !== S_START || bus.menu_selection !== 1'b0 || bus.hp !== 3'd0) begin
         n_fail++;
         $display("FAIL over_exit_values: state %0d sel %0d hp %0d, want 0 0 0",
                  bus.game_state, bus.menu_selection, bus.hp);
      end
   endtask

   initial begin
      test_reset();
      test_menu();
      test_move_left_and_floor();
      test_reset_midgame();
      test_pickup_deposit();
      test_hits();
      test_game_over_exit();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/game_controller.md
# game_controller

Frame-rate game engine that owns the game state machine, menu selection, player/obstacle/green-box positions, bank level and HP. Sits directly upstream of `vga_driver_memory`: every object-position, `game_state`, `menu_selection` and `bank_level` input of the renderer is a registered output of this block. Game objects advance once per `frame_tick`, which the VGA timing generator supplies at the start of vertical blanking.

## Interface
- `BOX_WIDTH`, 10'd30: player width, px
- `BOX_BASE_HEIGHT`, 10'd30: player height when empty-handed
- `BOX_Y_START`, 10'd315: floor baseline row, the bottom row of the player
- `BANK_X_START`, 10'd50 / `BANK_WIDTH`, 10'd60: deposit zone
- `OBJ_SIZE`, 10'd20: obstacle and green-box width and height
- `PLAYER_STEP`, 10'd4: px per frame
- `OBST_SPEED`, 10'd3: px per frame
- `START_HP`, 3'd3: HP at game start

Ports:
- `clk` in 1: pixel clock
- `rst_n` in 1: **synchronous, active-low** reset
- `frame_tick` in 1: one-cycle pulse per frame
- `btn_left`, `btn_right`, `btn_select` in 1 each: debounced, synchronized levels
- `game_state` out 2: 00 START, 01 PLAYING, 10 INSTRUCTIONS, 11 GAME_OVER
- `menu_selection` out 1: 0 = Start, 1 = How-to
- `player_x` out 10; `player_height` out 10
- `obstacle_x`, `obstacle_y`, `obstacle_width`, `obstacle_height` out 10 each
- `green_x`, `green_y`, `green_width`, `green_height` out 10 each; `green_active` out 1
- `bank_level` out 8; `hp` out 3

## Operation
- **Reset values:** all outputs are registered, and reset to the following.
  - `game_state` = START, `menu_selection` = 0, `bank_level` = 0, `hp` = `START_HP`.
  - `player_x` = 300, `player_height` = 30.
  - `obstacle_x` = 320, `obstacle_y` = 0.
  - `green_x` = 400, `green_y` = `BOX_Y_START`-`OBJ_SIZE`+1 (296), `green_active` = 1.
  - Widths and heights are always `OBJ_SIZE`.
- **Button edges:** the block registers each button's previous level. An edge is `btn & ~btn_prev`.
- **START state:**
  - A `btn_left` or `btn_right` edge toggles `menu_selection`.
  - A `btn_select` edge with selection 0 goes to PLAYING and reloads all game registers to their reset values. With selection 1 it goes to INSTRUCTIONS.
- **INSTRUCTIONS state:** a select edge goes to START.
- **GAME_OVER state:** a select edge goes to START and sets `menu_selection` = 0. Positions, `bank_level` and `hp` hold, so the renderer can still show the final score.
- **PLAYING state:** game registers update only on `frame_tick`. All checks use the pre-tick register values, and every update lands on the same edge.
  - **Player movement:** `btn_left` level (without right) moves the player by −`PLAYER_STEP`, clamped at 0. `btn_right` level (without left) moves it by +`PLAYER_STEP`, clamped at 640−`BOX_WIDTH` (610). Both held or neither: hold.
  - **Obstacle fall:** `obstacle_y` += `OBST_SPEED`.
  - **Hit:** the obstacle rect overlaps the player rect (player top = `BOX_Y_START`+1−`player_height`). Result: `hp` −1, and the obstacle respawns at y=0 with a new x.
  - **Floor:** `obstacle_y`+`OBJ_SIZE` > `BOX_Y_START` with no hit. Result: respawn only.
  - **Priority:** a hit has priority over the floor rule, and only one respawn occurs per tick.
  - **Pickup:** requires `green_active` and x-overlap of player and green box. Result: `green_active` = 0 and `player_height` = `BOX_BASE_HEIGHT`+`OBJ_SIZE` (50).
  - **Deposit:** requires `player_height` > `BOX_BASE_HEIGHT` and x-overlap with the bank. Result: `bank_level` +1, saturating at 255; `player_height` = 30; the green box respawns at a new x with `green_active` = 1.
  - **Game over:** if `hp` is 1 and a hit occurs, `hp` becomes 0 and the state becomes GAME_OVER on the same edge.
- **Spawn x:**
  - The x-source is a 10-bit Fibonacci LFSR (x^10+x^7+1, seed 10'h2A5) that advances every `clk`. Reset reseeds it; game restart does not.
  - Computation: x = 120 + `lfsr[8:0]`. If x ≥ 600, subtract 256. This gives a range of 120..599.
- **Width rules:** the block does all compares in 11 bits, so sums cannot wrap.

## Timing
- Button-edge latency: `game_state` and `menu_selection` change on the edge after the first cycle the button is sampled high. Holding the button causes no repeat.
- Frame update latency: outputs change on the clock edge that samples `frame_tick`=1, and are stable for the rest of the frame.
- `frame_tick` outside PLAYING: ignored.
- Simultaneous select edge and `frame_tick` on entry to PLAYING: the reload wins, and no move is applied.
- `rst_n` low mid-game: all registers return to their reset values on the next edge, regardless of state.

## Structure
- Package `game_pkg` holds the following:
  - State encodings S_START/S_PLAYING/S_INSTRUCTIONS/S_GAME_OVER, shared with `vga_driver_memory`.
  - The geometry constants BOX_*, BANK_* and OBJ_SIZE.
  - The reset and spawn constants.
- Sub-module `game_lfsr`: 10-bit LFSR with `clk`/`rst_n`, outputting `lfsr[9:0]`.

## Test plan
- Reset, then idle 3 frames → outputs hold their reset values (`hp`=3, START).
- `btn_right` edge, then select edge → `menu_selection`=1, then INSTRUCTIONS. Select again → START.
- PLAYING with `btn_left` held for 80 frames → `player_x` goes 300→0 in 75 frames and holds at 0. With `btn_right` from 600, it clamps at 610.
- Pickup and deposit: set `player_x`=390, tick → `green_active`=0, height 50. Move to x=60, tick → `bank_level`=1, height 30, green respawns with x in 120..599.
- Three hits → `hp` 3→2→1→0 and GAME_OVER on the third hit's edge. Obstacle-on-floor with no overlap → respawn, `hp` unchanged.
- `rst_n` low for one cycle during PLAYING → all reset values on the next edge.
